// File: rtl/sap_controller.sv
// SAP-1 style microcode controller: sequences IDLE, fetch (T1..T3),
// execute (T4..T6) and HALT, decoding bus/load controls from state and opcode.
module sap_controller #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       pc_inc,
    output logic       pc_en,
    output logic       mar_load,
    output logic       ram_en,
    output logic       ir_load,
    output logic       ir_en,
    output logic       a_load,
    output logic       a_en,
    output logic       b_load,
    output logic       add,
    output logic       sub,
    output logic       alu_en,
    output logic       out_load,
    output logic       halt,
    output logic [5:0] t_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_T4   = 3'd4;
    localparam logic [2:0] S_T5   = 3'd5;
    localparam logic [2:0] S_T6   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    logic [2:0] state_q;
    logic [2:0] state_d;

    // Opcode classes shared by the execute-phase decode.
    logic is_lda, is_add, is_sub, is_out;
    assign is_lda = (opcode == OP_LDA);
    assign is_add = (opcode == OP_ADD);
    assign is_sub = (opcode == OP_SUB);
    assign is_out = (opcode == OP_OUT);

    // Next-state: run is only consulted at instruction boundaries (IDLE, T6).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = run ? S_T1 : S_IDLE;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_T4;
            S_T4:    state_d = (opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = run ? S_T1 : S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any instruction straight back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Control decode: purely combinational so reset clears every output at once.
    always_comb begin
        pc_inc   = 1'b0;
        pc_en    = 1'b0;
        mar_load = 1'b0;
        ram_en   = 1'b0;
        ir_load  = 1'b0;
        ir_en    = 1'b0;
        a_load   = 1'b0;
        a_en     = 1'b0;
        b_load   = 1'b0;
        add      = 1'b0;
        sub      = 1'b0;
        alu_en   = 1'b0;
        out_load = 1'b0;
        halt     = 1'b0;
        case (state_q)
            S_T1: begin
                pc_en    = 1'b1;
                mar_load = 1'b1;
            end
            S_T2: pc_inc = 1'b1;
            S_T3: begin
                ram_en  = 1'b1;
                ir_load = 1'b1;
            end
            S_T4: begin
                if (is_lda || is_add || is_sub) begin
                    ir_en    = 1'b1;
                    mar_load = 1'b1;
                end else if (is_out) begin
                    a_en     = 1'b1;
                    out_load = 1'b1;
                end
            end
            S_T5: begin
                if (is_lda) begin
                    ram_en = 1'b1;
                    a_load = 1'b1;
                end else if (is_add || is_sub) begin
                    ram_en = 1'b1;
                    b_load = 1'b1;
                end
            end
            S_T6: begin
                if (is_add) begin
                    alu_en = 1'b1;
                    add    = 1'b1;
                    a_load = 1'b1;
                end else if (is_sub) begin
                    alu_en = 1'b1;
                    sub    = 1'b1;
                    a_load = 1'b1;
                end
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

    // One-hot ring-counter view of the T-state; zero in IDLE and HALT.
    always_comb begin
        t_state = 6'b000000;
        case (state_q)
            S_T1:    t_state = 6'b000001;
            S_T2:    t_state = 6'b000010;
            S_T3:    t_state = 6'b000100;
            S_T4:    t_state = 6'b001000;
            S_T5:    t_state = 6'b010000;
            S_T6:    t_state = 6'b100000;
            default: t_state = 6'b000000;
        endcase
    end

endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller: walks LDA/ADD/SUB/OUT/NOP/HLT,
// mid-instruction run drop and asynchronous resets, with hand-derived controls.
module tb_sap_controller;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic       pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en;
    logic       a_load, a_en, b_load, add, sub, alu_en, out_load, halt;
    logic [5:0] t_state;

    int total = 0;
    int bad   = 0;

    // Control vector bit assignments.
    localparam logic [12:0] PC_INC   = 13'h1000;
    localparam logic [12:0] PC_EN    = 13'h0800;
    localparam logic [12:0] MAR_LOAD = 13'h0400;
    localparam logic [12:0] RAM_EN   = 13'h0200;
    localparam logic [12:0] IR_LOAD  = 13'h0100;
    localparam logic [12:0] IR_EN    = 13'h0080;
    localparam logic [12:0] A_LOAD   = 13'h0040;
    localparam logic [12:0] A_EN     = 13'h0020;
    localparam logic [12:0] B_LOAD   = 13'h0010;
    localparam logic [12:0] ADD      = 13'h0008;
    localparam logic [12:0] SUB      = 13'h0004;
    localparam logic [12:0] ALU_EN   = 13'h0002;
    localparam logic [12:0] OUT_LOAD = 13'h0001;
    localparam logic [12:0] NONE     = 13'h0000;

    logic [12:0] ctl;
    assign ctl = {pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en,
                  a_load, a_en, b_load, add, sub, alu_en, out_load};

    // Tiny A/B register model driven by the controller's ALU controls.
    logic [7:0] a_m;
    logic [7:0] b_m;

    sap_controller dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .opcode   (opcode),
        .pc_inc   (pc_inc),
        .pc_en    (pc_en),
        .mar_load (mar_load),
        .ram_en   (ram_en),
        .ir_load  (ir_load),
        .ir_en    (ir_en),
        .a_load   (a_load),
        .a_en     (a_en),
        .b_load   (b_load),
        .add      (add),
        .sub      (sub),
        .alu_en   (alu_en),
        .out_load (out_load),
        .halt     (halt),
        .t_state  (t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the current outputs (no clock advance).
    task automatic look(input string tag, input logic [5:0] et, input logic [12:0] ec, input logic eh);
        check({tag, ".t_state"}, 32'(t_state), 32'(et));
        check({tag, ".ctl"},     32'(ctl),     32'(ec));
        check({tag, ".halt"},    32'(halt),    32'(eh));
        check({tag, ".bus1"},    32'($onehot0({pc_en, ram_en, ir_en, a_en, alu_en})), 32'd1);
        check({tag, ".addsub"},  32'(add & sub), 32'd0);
    endtask

    // Advance one clock and check just after the rising edge.
    task automatic cyc(input string tag, input logic [5:0] et, input logic [12:0] ec, input logic eh);
        @(posedge clk);
        #1;
        look(tag, et, ec, eh);
    endtask

    task automatic fetch(input string tag);
        cyc({tag, ".T1"}, 6'b000001, PC_EN | MAR_LOAD, 1'b0);
        cyc({tag, ".T2"}, 6'b000010, PC_INC, 1'b0);
        cyc({tag, ".T3"}, 6'b000100, RAM_EN | IR_LOAD, 1'b0);
    endtask

    initial begin
        rst    = 1'b0;
        run    = 1'b0;
        opcode = 4'h0;
        a_m    = 8'h07;
        b_m    = 8'h03;

        // Held in reset: everything quiet.
        #2;
        look("rst_async", 6'd0, NONE, 1'b0);
        cyc("rst_hold", 6'd0, NONE, 1'b0);

        // Release with run=1: T1 on the first edge. LDA.
        rst = 1'b1; run = 1'b1; opcode = 4'h0;
        fetch("lda");
        cyc("lda.T4", 6'b001000, IR_EN | MAR_LOAD, 1'b0);
        cyc("lda.T5", 6'b010000, RAM_EN | A_LOAD, 1'b0);
        cyc("lda.T6", 6'b100000, NONE, 1'b0);

        // ADD
        opcode = 4'h1;
        fetch("add");
        cyc("add.T4", 6'b001000, IR_EN | MAR_LOAD, 1'b0);
        cyc("add.T5", 6'b010000, RAM_EN | B_LOAD, 1'b0);
        cyc("add.T6", 6'b100000, ALU_EN | ADD | A_LOAD, 1'b0);

        // SUB with A=7, B=3 in the model: A becomes 4.
        opcode = 4'h2;
        fetch("sub");
        cyc("sub.T4", 6'b001000, IR_EN | MAR_LOAD, 1'b0);
        cyc("sub.T5", 6'b010000, RAM_EN | B_LOAD, 1'b0);
        cyc("sub.T6", 6'b100000, ALU_EN | SUB | A_LOAD, 1'b0);
        if (alu_en && a_load) a_m = add ? a_m + b_m : (sub ? a_m - b_m : a_m);
        check("sub.A", 32'(a_m), 32'h04);

        // OUT
        opcode = 4'hE;
        fetch("out");
        cyc("out.T4", 6'b001000, A_EN | OUT_LOAD, 1'b0);
        cyc("out.T5", 6'b010000, NONE, 1'b0);
        cyc("out.T6", 6'b100000, NONE, 1'b0);

        // Undefined opcode runs as a 6-cycle NOP.
        opcode = 4'h7;
        fetch("nop");
        cyc("nop.T4", 6'b001000, NONE, 1'b0);
        cyc("nop.T5", 6'b010000, NONE, 1'b0);
        cyc("nop.T6", 6'b100000, NONE, 1'b0);

        // LDA with run dropped during T3: completes, then parks in IDLE.
        opcode = 4'h0;
        fetch("drop");
        run = 1'b0;
        cyc("drop.T4", 6'b001000, IR_EN | MAR_LOAD, 1'b0);
        cyc("drop.T5", 6'b010000, RAM_EN | A_LOAD, 1'b0);
        cyc("drop.T6", 6'b100000, NONE, 1'b0);
        cyc("drop.idle0", 6'd0, NONE, 1'b0);
        cyc("drop.idle1", 6'd0, NONE, 1'b0);
        run = 1'b1;
        opcode = 4'h1;

        // ADD with an asynchronous reset pulse in T5.
        fetch("arst");
        cyc("arst.T4", 6'b001000, IR_EN | MAR_LOAD, 1'b0);
        cyc("arst.T5", 6'b010000, RAM_EN | B_LOAD, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        look("arst.mid", 6'd0, NONE, 1'b0);
        cyc("arst.hold", 6'd0, NONE, 1'b0);
        rst = 1'b1;
        opcode = 4'hF;

        // HLT after restart: 4 cycles then HALT forever.
        fetch("hlt");
        cyc("hlt.T4", 6'b001000, NONE, 1'b0);
        run = 1'b0;
        for (int i = 0; i < 20; i++) cyc("hlt.halt", 6'd0, NONE, 1'b1);
        run = 1'b1;
        cyc("hlt.halt_run", 6'd0, NONE, 1'b1);

        // Reset out of HALT clears halt asynchronously, then restarts.
        #2;
        rst = 1'b0;
        #1;
        look("hrst.mid", 6'd0, NONE, 1'b0);
        cyc("hrst.hold", 6'd0, NONE, 1'b0);
        rst = 1'b1;
        opcode = 4'h0;
        cyc("hrst.T1", 6'b000001, PC_EN | MAR_LOAD, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap_controller.md
SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 Parameter OP_LDA, default 4'h0, LDA opcode.
REQ-002 Parameter OP_ADD, default 4'h1, ADD opcode.
REQ-003 Parameter OP_SUB, default 4'h2, SUB opcode.
REQ-004 Parameter OP_OUT, default 4'hE, OUT opcode.
REQ-005 Parameter OP_HLT, default 4'hF, HLT opcode.
REQ-006 Port clk  in  1  clock; all state changes on rising edge.
REQ-007 Port rst  in  1  reset; asynchronous, active-low.
REQ-008 Port run  in  1  1 = fetch/execute instructions; 0 = park in IDLE at the instruction boundary.
REQ-009 Port opcode  in  4  instruction-register opcode field; stable T4..T6.
REQ-010 Port pc_inc  out  1  program counter increment.
REQ-011 Port pc_en  out  1  PC drives bus.
REQ-012 Port mar_load  out  1  MAR loads from bus.
REQ-013 Port ram_en  out  1  RAM drives bus.
REQ-014 Port ir_load  out  1  IR loads from bus.
REQ-015 Port ir_en  out  1  IR address field drives bus.
REQ-016 Port a_load, a_en  out  1 each  register A load / drive (Reg load_a / enable_a).
REQ-017 Port b_load  out  1  register B load (Reg load_b).
REQ-018 Port add, sub, alu_en  out  1 each  ALU operation selects and ALU-drives-bus.
REQ-019 Port out_load  out  1  output register load.
REQ-020 Port halt  out  1  controller halted.
REQ-021 Port t_state  out  6  one-hot T1..T6 (bit0 = T1); 0 in IDLE and HALT.

Function
REQ-022 States: IDLE, T1..T6, HALT; state register only; outputs are decoded combinationally from state and opcode.
REQ-023 IDLE: run=1 -> T1, else stay in IDLE; all controls 0.
REQ-024 T1->T2->T3->T4 unconditionally; T4->HALT if opcode==OP_HLT, else T4->T5; T5->T6.
REQ-025 T6: run=1 -> T1; run=0 -> IDLE.
REQ-026 HALT: stays in HALT until reset; halt=1; all other controls 0.
REQ-027 Fetch, for all opcodes: T1 pc_en+mar_load; T2 pc_inc; T3 ram_en+ir_load.
REQ-028 LDA: T4 ir_en+mar_load; T5 ram_en+a_load; T6 none.
REQ-029 ADD: T4 ir_en+mar_load; T5 ram_en+b_load; T6 alu_en+add+a_load.
REQ-030 SUB: as ADD, except T6 asserts alu_en+sub+a_load, and add=0.
REQ-031 OUT: T4 a_en+out_load; T5, T6 none.
REQ-032 HLT: T4 has no controls; halt asserts from the next cycle.
REQ-033 Undefined opcode executes as NOP: no controls T4..T6; the sequence continues.
REQ-034 At most one of pc_en, ram_en, ir_en, a_en, alu_en is 1 in any cycle.
REQ-035 add and sub are never both 1.
REQ-036 Each instruction occupies exactly 6 cycles T1..T6; HLT occupies 4 cycles before HALT.
REQ-037 run is sampled only in IDLE and T6; a run deassert mid-instruction completes the instruction.

Reset
REQ-038 rst=0 forces IDLE immediately, independent of clk.
REQ-039 While rst=0, all control outputs, halt and t_state are 0.
REQ-040 A reset in any state, including mid-instruction and HALT, aborts to IDLE; no partial controls are asserted afterwards.
REQ-041 After rst release with run=1, T1 begins on the first rising edge.

Verification
REQ-042 Reset, run=1, opcode=OP_LDA -> t_state 000001..100000 over 6 cycles; pc_en+mar_load in T1; ram_en+a_load in T5.
REQ-043 opcode=OP_SUB -> T6 has alu_en=1, sub=1, a_load=1, add=0; the ALU on A=8'h07, B=8'h03 yields 8'h04 loaded into A.
REQ-044 opcode=OP_HLT -> halt=1 from cycle 5 onward; all controls 0 and t_state=0 for 20 further cycles.
REQ-045 run drops during T3 -> the instruction completes through T6, then IDLE with t_state=0; run=1 -> T1 next edge.
REQ-046 rst pulsed low asynchronously in T5 of ADD -> outputs 0 within the same cycle, with no b_load or a_load pulse; after release, restart at T1.
REQ-047 opcode=4'h7 -> 6-cycle NOP; no bus-drive or load outputs in T4..T6; the next fetch proceeds normally.
